// File: rtl/cpu_pkg.sv
// Shared CPU front-end types and constants for the instruction prefetch queue.
// Holds widths, the PC step, the NOP returned on an empty queue and the
// prefetch state encoding, plus a small PC increment helper.
package cpu_pkg;

    localparam int INST_W = 32;
    localparam int ADDR_W = 32;

    // One instruction word per fetch; addresses are byte addresses.
    localparam logic [ADDR_W-1:0] PC_STEP  = 32'd4;
    localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0000;

    // RUN: every response is kept. DRAIN: stale responses are still in flight.
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1
    } pfq_state_t;

    // Sequential fetch address; wraps modulo 2^32 naturally.
    function automatic logic [ADDR_W-1:0] pc_next(input logic [ADDR_W-1:0] pc);
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/pfq_fifo.sv
// Synchronous FIFO for the prefetch queue. Pointers carry one extra MSB so
// full and empty are told apart without a separate counter. The head entry is
// read combinationally so a word pushed in one cycle is visible the next.
// clear empties the queue in one cycle and has priority over push/pop.
module pfq_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = ADDR_W + INST_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   clear,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      wr_ptr_d;
    logic [AW:0]      rd_ptr_q;
    logic [AW:0]      rd_ptr_d;
    logic             do_push;
    logic             do_pop;

    // Status flags, qualified handshakes and next pointer values
    always_comb begin
        count    = wr_ptr_q - rd_ptr_q;
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        do_push  = push && !full && !clear;
        do_pop   = pop && !empty && !clear;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
        end
    end

    // Pointer registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage write; contents need no reset because empty masks the head
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata;
        end
    end

    assign rdata = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/if_prefetch_queue.sv
// Instruction prefetch front end. Issues in-order fetches under a credit rule
// (queued + outstanding < DEPTH) so every response has a slot, buffers
// {pc, word} pairs in pfq_fifo and presents the head to decode via
// valid/ready. A redirect flushes the queue and counts the in-flight
// responses that must be thrown away when they return.
// Optional build macro: PFQ_STATS_EN adds flush and empty-cycle counters.
module if_prefetch_queue
    import cpu_pkg::*;
#(
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_resp_valid,
    input  logic [INST_W-1:0] imem_resp_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst_out,
    output logic [ADDR_W-1:0] inst_pc
`ifdef PFQ_STATS_EN
    ,
    output logic [31:0]       stat_flush_cnt,
    output logic [31:0]       stat_empty_cnt
`endif
);

    localparam int CW       = $clog2(DEPTH) + 1;
    localparam int CREDIT_W = CW + 1;
    localparam int ENTRY_W  = ADDR_W + INST_W;

    logic [ADDR_W-1:0]   fetch_pc_q;
    logic [ADDR_W-1:0]   fetch_pc_d;
    logic [ADDR_W-1:0]   resp_pc_q;
    logic [ADDR_W-1:0]   resp_pc_d;
    logic [CW-1:0]       outstanding_q;
    logic [CW-1:0]       outstanding_d;
    logic [CW-1:0]       drop_cnt_q;
    logic [CW-1:0]       drop_cnt_d;
    pfq_state_t          state_q;
    pfq_state_t          state_d;

    logic [CREDIT_W-1:0] credit_sum;
    logic                credit_ok;
    logic                req_fire;

    logic                fifo_push;
    logic                fifo_pop;
    logic                fifo_clear;
    logic [ENTRY_W-1:0]  fifo_wdata;
    logic [ENTRY_W-1:0]  fifo_rdata;
    logic                fifo_full;
    logic                fifo_empty;
    logic [CW-1:0]       fifo_count;

    pfq_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .clear (fifo_clear),
        .wdata (fifo_wdata),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Credit check, fetch/decode handshakes and head-of-queue outputs
    always_comb begin
        credit_sum     = {1'b0, fifo_count} + {1'b0, outstanding_q};
        credit_ok      = credit_sum < CREDIT_W'(DEPTH);
        // Held off while in reset so nothing is requested before fetch_pc is valid.
        imem_req_valid = reset && credit_ok && !redirect_valid;
        imem_req_addr  = fetch_pc_q;
        req_fire       = imem_req_valid && imem_req_ready;
        inst_valid     = !fifo_empty && !redirect_valid;
        fifo_pop       = inst_valid && inst_ready;
        inst_out       = fifo_empty ? NOP_INST : fifo_rdata[INST_W-1:0];
        inst_pc        = fifo_empty ? '0 : fifo_rdata[ENTRY_W-1:INST_W];
    end

    // Next PC, outstanding/drop bookkeeping and queue push/clear decisions
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        outstanding_d = outstanding_q + CW'(req_fire) - CW'(imem_resp_valid);
        drop_cnt_d    = drop_cnt_q;
        fifo_push     = 1'b0;
        fifo_clear    = 1'b0;
        fifo_wdata    = {resp_pc_q, imem_resp_data};
        if (redirect_valid) begin
            // Everything still in flight after this cycle belongs to the old
            // path; a response landing this cycle is simply not pushed.
            fifo_clear = 1'b1;
            fetch_pc_d = redirect_pc;
            resp_pc_d  = redirect_pc;
            drop_cnt_d = outstanding_d;
        end else begin
            if (req_fire) begin
                fetch_pc_d = pc_next(fetch_pc_q);
            end
            if (imem_resp_valid) begin
                if (state_q == DRAIN) begin
                    drop_cnt_d = drop_cnt_q - CW'(1);
                end else if (!fifo_full) begin
                    fifo_push = 1'b1;
                    resp_pc_d = pc_next(resp_pc_q);
                end
            end
        end
    end

    // Prefetch state follows whether stale responses remain to be dropped
    always_comb begin
        state_d = (drop_cnt_d != '0) ? DRAIN : RUN;
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            state_q       <= RUN;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            state_q       <= state_d;
        end
    end

`ifdef PFQ_STATS_EN
    logic [31:0] stat_flush_q;
    logic [31:0] stat_empty_q;

    // Saturating counters of redirects and of cycles with nothing for decode
    always_ff @(posedge clk) begin
        if (!reset) begin
            stat_flush_q <= '0;
            stat_empty_q <= '0;
        end else begin
            if (redirect_valid && (stat_flush_q != 32'hFFFF_FFFF)) begin
                stat_flush_q <= stat_flush_q + 32'd1;
            end
            if (!inst_valid && (stat_empty_q != 32'hFFFF_FFFF)) begin
                stat_empty_q <= stat_empty_q + 32'd1;
            end
        end
    end

    assign stat_flush_cnt = stat_flush_q;
    assign stat_empty_cnt = stat_empty_q;
`endif

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Bench for if_prefetch_queue: a behavioural imem with fixed latency, an
// epoch-tagged scoreboard of expected {pc, word} pairs, a table of scenario
// vectors and a few hand-written corner-case sequences.
module tb_if_prefetch_queue;

    logic        clk;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
`ifdef PFQ_STATS_EN
    logic [31:0] stat_flush_cnt;
    logic [31:0] stat_empty_cnt;
`endif

    if_prefetch_queue #(
        .DEPTH    (4),
        .RESET_PC (32'h0)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst_out        (inst_out),
        .inst_pc         (inst_pc)
`ifdef PFQ_STATS_EN
        ,
        .stat_flush_cnt  (stat_flush_cnt),
        .stat_empty_cnt  (stat_empty_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } req_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } ent_t;

    typedef struct {
        int          lat;
        int          stall;
        int          win;
        int          exp_fires;
        int          redir_at;
        logic [31:0] redir_pc;
        logic [31:0] exp_first;
    } vec_t;

    req_t pend[$];
    ent_t expq[$];
    req_t cur_resp;
    logic have_resp;
    int   epoch;
    int   cyc;
    int   lat;
    logic [31:0] exp_fetch;

    logic        s_req_fire;
    logic        s_pop;
    logic        s_inst_valid;
    logic [31:0] s_pc;

    int checks;
    int failures;

    vec_t vecs[5];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'd2654435761) ^ 32'h5A5A_1234;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Sample one cycle at the negedge, update the models, then advance to the
    // next cycle and drive the imem response for it.
    task automatic step();
        ent_t e;
        req_t r;
        @(negedge clk);
        s_req_fire   = imem_req_valid && imem_req_ready;
        s_pop        = inst_valid && inst_ready;
        s_inst_valid = inst_valid;
        s_pc         = inst_pc;
        if (imem_req_valid) chk("req_addr", imem_req_addr, exp_fetch);
        if (redirect_valid) begin
            chk("redir_no_req", 32'(imem_req_valid), 32'd0);
            chk("redir_no_inst", 32'(inst_valid), 32'd0);
        end
        if (s_pop) begin
            if (expq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL pop_unexpected: got pc %h expected no instruction", inst_pc);
            end else begin
                e = expq.pop_front();
                chk("inst_pc", inst_pc, e.pc);
                chk("inst_out", inst_out, e.data);
            end
        end
        if (redirect_valid) begin
            epoch++;
            expq.delete();
            exp_fetch = redirect_pc;
        end else if (s_req_fire) begin
            exp_fetch = exp_fetch + 32'd4;
        end
        if (have_resp && cur_resp.epoch == epoch) begin
            e.pc   = cur_resp.addr;
            e.data = mem_word(cur_resp.addr);
            expq.push_back(e);
        end
        if (s_req_fire) begin
            r.addr  = imem_req_addr;
            r.epoch = epoch;
            r.due   = cyc + lat;
            pend.push_back(r);
        end
        @(posedge clk);
        #1;
        cyc++;
        redirect_valid = 1'b0;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            cur_resp        = pend.pop_front();
            have_resp       = 1'b1;
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_word(cur_resp.addr);
        end else begin
            have_resp       = 1'b0;
            imem_resp_valid = 1'b0;
            imem_resp_data  = '0;
        end
    endtask

    // Hold reset for two edges (imem model resets too); optionally check outputs.
    task automatic do_reset(input logic check);
        reset           = 1'b0;
        redirect_valid  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        have_resp       = 1'b0;
        pend.delete();
        expq.delete();
        epoch++;
        exp_fetch = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        if (check) begin
            chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
            chk("rst_req_addr", imem_req_addr, 32'h0);
            chk("rst_inst_valid", 32'(inst_valid), 32'd0);
            chk("rst_inst_out", inst_out, 32'h0);
            chk("rst_inst_pc", inst_pc, 32'h0);
`ifdef PFQ_STATS_EN
            chk("rst_stat_flush", stat_flush_cnt, 32'd0);
            chk("rst_stat_empty", stat_empty_cnt, 32'd0);
`endif
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        cyc   = 0;
    endtask

    initial begin
        int fires;
        int pops;
        int first_c;
        int bad;
        logic got;
        logic [31:0] first_pc;

        checks = 0;
        failures = 0;
        epoch = 0;
        cyc = 0;
        lat = 1;
        reset = 1'b0;
        imem_req_ready = 1'b1;
        imem_resp_valid = 1'b0;
        imem_resp_data = '0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        inst_ready = 1'b1;
        have_resp = 1'b0;
        exp_fetch = 32'h0;

        //            lat stall win fires redir redir_pc      first
        vecs[0] = '{1,   0,   6,  6,  -1, 32'h0,        32'h0};
        vecs[1] = '{1,  10,  10,  4,  -1, 32'h0,        32'h0};
        vecs[2] = '{3,   0,   3,  3,   3, 32'h100,      32'h100};
        vecs[3] = '{2,   0,   4,  4,   5, 32'hFFFF_FFF8, 32'hFFFF_FFF8};
        vecs[4] = '{3,  10,  10,  4,  12, 32'h40,       32'h40};

        // Reset state, then back-to-back streaming with latency 1
        do_reset(1'b1);
        lat = 1;
        inst_ready = 1'b1;
        fires = 0;
        pops = 0;
        first_c = -1;
        for (int c = 0; c < 12; c++) begin
            step();
            if (s_inst_valid && first_c < 0) first_c = c;
            if (s_pop) pops++;
            if (s_req_fire) fires++;
        end
        chk("t1_first_valid_cycle", 32'(first_c), 32'd2);
        chk("t1_pops", 32'(pops), 32'd10);
        chk("t1_fires", 32'(fires), 32'd12);

        // Scenario table
        for (int v = 0; v < 5; v++) begin
            do_reset(1'b0);
            lat = vecs[v].lat;
            imem_req_ready = 1'b1;
            fires = 0;
            got = 1'b0;
            first_pc = 32'hDEAD_BEEF;
            for (int c = 0; c < 30; c++) begin
                inst_ready = (c >= vecs[v].stall);
                if (c == vecs[v].redir_at) begin
                    redirect_valid = 1'b1;
                    redirect_pc = vecs[v].redir_pc;
                end
                step();
                if (c < vecs[v].win && s_req_fire) fires++;
                if (c > vecs[v].redir_at && s_pop && !got) begin
                    got = 1'b1;
                    first_pc = s_pc;
                end
            end
            chk($sformatf("vec%0d_fires", v), 32'(fires), 32'(vecs[v].exp_fires));
            chk($sformatf("vec%0d_first_pc", v), first_pc, vecs[v].exp_first);
        end

        // Reset with a full queue clears everything; restart fetches from 0
        do_reset(1'b0);
        lat = 1;
        inst_ready = 1'b0;
        for (int c = 0; c < 10; c++) step();
        do_reset(1'b1);
        inst_ready = 1'b1;
        got = 1'b0;
        first_pc = 32'hDEAD_BEEF;
        for (int c = 0; c < 6; c++) begin
            step();
            if (s_pop && !got) begin
                got = 1'b1;
                first_pc = s_pc;
            end
        end
        chk("rst_mid_first_pc", first_pc, 32'h0);

        // Redirect in the same cycle as a response and a ready pop
        do_reset(1'b0);
        lat = 1;
        inst_ready = 1'b1;
        for (int c = 0; c < 5; c++) step();
        redirect_valid = 1'b1;
        redirect_pc = 32'h500;
        step();
        chk("t4_no_pop", 32'(s_pop), 32'd0);
        step();
        chk("t4_queue_empty", 32'(s_inst_valid), 32'd0);
        got = 1'b0;
        first_pc = 32'hDEAD_BEEF;
        for (int c = 0; c < 6; c++) begin
            step();
            if (s_pop && !got) begin
                got = 1'b1;
                first_pc = s_pc;
            end
        end
        chk("t4_first_pc", first_pc, 32'h500);

        // Two redirects close together: no word from the first target survives
        do_reset(1'b0);
        lat = 3;
        inst_ready = 1'b1;
        for (int c = 0; c < 5; c++) step();
        redirect_valid = 1'b1;
        redirect_pc = 32'h200;
        step();
        step();
        redirect_valid = 1'b1;
        redirect_pc = 32'h300;
        step();
        bad = 0;
        got = 1'b0;
        first_pc = 32'hDEAD_BEEF;
        for (int c = 0; c < 15; c++) begin
            step();
            if (s_pop && s_pc[31:8] == 24'h2) bad++;
            if (s_pop && !got) begin
                got = 1'b1;
                first_pc = s_pc;
            end
        end
        chk("t5_first_pc", first_pc, 32'h300);
        chk("t5_stale_words", 32'(bad), 32'd0);

`ifdef PFQ_STATS_EN
        // Three idle cycles plus two redirect cycles
        do_reset(1'b0);
        lat = 1;
        imem_req_ready = 1'b0;
        inst_ready = 1'b1;
        for (int c = 0; c < 3; c++) step();
        redirect_valid = 1'b1;
        redirect_pc = 32'h0;
        step();
        redirect_valid = 1'b1;
        redirect_pc = 32'h0;
        step();
        chk("stat_flush", stat_flush_cnt, 32'd2);
        chk("stat_empty", stat_empty_cnt, 32'd5);
        do_reset(1'b1);
        imem_req_ready = 1'b1;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
